usb_trans_sched: RTL and testbench

USB_TRANS_SCHED -- requirements
Module: usb_trans_sched

---
 rtl/usb_trans_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_usb_trans_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_trans_sched.sv
`default_nettype none
// ============================================================================
// Module   : usb_trans_sched
// Brief    : Decodes PC transfer commands, streams OUT words to the memory mux
//            and returns the key/status block as an 8-word IN burst.
// Revision : 1.0 - initial release
// ============================================================================
module usb_trans_sched #(
  parameter logic [31:0] CODE_BYTES   = 32'h01000000,
  parameter logic [31:0] VFRAME_BYTES = 32'h00020000,
  parameter logic [31:0] SND_BYTES    = 32'h00000010,
  parameter int unsigned TIMEOUT_CYC  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ctrl_tdata,
  input  logic        ctrl_tvalid,
  output logic        ctrl_tready,
  input  logic [31:0] tx_tdata,
  input  logic        tx_tvalid,
  output logic        tx_tready,
  output logic        mux_wr,
  input  logic        mux_wr_ready,
  output logic [2:0]  mux_trans_type,
  output logic [31:0] mux_wr_data,
  output logic [31:0] rx_tdata,
  output logic        rx_tvalid,
  output logic        rx_tlast,
  input  logic        rx_tready,
  output logic [2:0]  ks_idx,
  input  logic [31:0] ks_data,
  output logic        busy,
  output logic [2:0]  cur_type,
  output logic [23:0] words_remain,
  output logic        abort,
  output logic        bad_cmd
);

  localparam logic [2:0] T_NONE   = 3'b000;
  localparam logic [2:0] T_CODE   = 3'b001;
  localparam logic [2:0] T_VBUF   = 3'b010;
  localparam logic [2:0] T_KS     = 3'b011;
  localparam logic [2:0] T_BAD4   = 3'b100;
  localparam logic [2:0] T_SRBUF  = 3'b101;
  localparam logic [2:0] T_SLBUF  = 3'b110;
  localparam logic [2:0] T_BAD7   = 3'b111;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_OUT    = 2'd1;
  localparam logic [1:0] S_IN     = 2'd2;

  localparam logic [31:0] CODE_W32 = CODE_BYTES >> 2;
  localparam logic [31:0] VFRM_W32 = VFRAME_BYTES >> 2;
  localparam logic [31:0] SND_W32  = SND_BYTES >> 2;
  localparam logic [23:0] CODE_WORDS = CODE_W32[23:0];
  localparam logic [23:0] VFRM_WORDS = VFRM_W32[23:0];
  localparam logic [23:0] SND_WORDS  = SND_W32[23:0];
  localparam logic [31:0] TO_LIMIT   = TIMEOUT_CYC;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cur_type_q, cur_type_d;
  logic [23:0] words_q, words_d;
  logic [2:0]  ks_idx_q, ks_idx_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        abort_q, abort_d;
  logic        bad_cmd_q, bad_cmd_d;
  logic        mux_wr_q, mux_wr_d;
  logic [2:0]  mux_type_q, mux_type_d;
  logic [31:0] mux_data_q, mux_data_d;

  logic [2:0]  cmd;
  logic        cmd_hs;
  logic        tx_hs;
  logic        rx_hs;
  logic        timeout_hit;
  logic        unused_cmd_bits;

  assign cmd             = ctrl_tdata[2:0];
  assign unused_cmd_bits = ^ctrl_tdata[31:3];
  assign cmd_hs          = ctrl_tvalid & ctrl_tready;
  assign tx_hs           = tx_tvalid & tx_tready;
  assign rx_hs           = rx_tvalid & rx_tready;
  // Stall cycles only count while the mux could have taken a word.
  assign timeout_hit     = (state_q == S_OUT) & tx_tready & ~tx_tvalid
                           & ((to_cnt_q + 32'd1) == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          case (cmd)
            T_CODE, T_VBUF, T_SRBUF, T_SLBUF: state_d = S_OUT;
            T_KS:                             state_d = S_IN;
            default:                          state_d = S_IDLE;
          endcase
        end
      end
      S_OUT: begin
        if ((tx_hs && words_q == 24'd1) || timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_IN: begin
        if (rx_hs && ks_idx_q == 3'd7) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_tready = (state_q == S_IDLE);
    tx_tready   = (state_q == S_OUT) & (~mux_wr_q | mux_wr_ready);
    rx_tvalid   = (state_q == S_IN);
    rx_tdata    = ks_data;
    rx_tlast    = (state_q == S_IN) & (ks_idx_q == 3'd7);
    busy        = (state_q != S_IDLE);
  end

  always_comb begin
    cur_type_d = cur_type_q;
    words_d    = words_q;
    ks_idx_d   = ks_idx_q;
    to_cnt_d   = to_cnt_q;
    abort_d    = 1'b0;
    bad_cmd_d  = 1'b0;
    mux_wr_d   = mux_wr_q;
    mux_type_d = mux_type_q;
    mux_data_d = mux_data_q;

    if (cmd_hs) begin
      case (cmd)
        T_CODE:  begin cur_type_d = cmd; words_d = CODE_WORDS; end
        T_VBUF:  begin cur_type_d = cmd; words_d = VFRM_WORDS; end
        T_SRBUF: begin cur_type_d = cmd; words_d = SND_WORDS;  end
        T_SLBUF: begin cur_type_d = cmd; words_d = SND_WORDS;  end
        T_KS: begin
          cur_type_d = cmd;
          words_d    = 24'd8;
          ks_idx_d   = 3'd0;
        end
        T_BAD4, T_BAD7: bad_cmd_d = 1'b1;
        default: ;
      endcase
    end

    if (state_q != S_OUT || tx_hs) begin
      to_cnt_d = 32'd0;
    end else if (timeout_hit) begin
      to_cnt_d = 32'd0;
      abort_d  = 1'b1;
      words_d  = 24'd0;
    end else if (tx_tready) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end

    if (tx_hs) begin
      words_d = words_q - 24'd1;
    end

    if (rx_hs) begin
      words_d  = words_q - 24'd1;
      ks_idx_d = (ks_idx_q == 3'd7) ? 3'd0 : ks_idx_q + 3'd1;
    end

    // The held word carries its own type, so a new command may start under it.
    if (tx_hs) begin
      mux_wr_d   = 1'b1;
      mux_type_d = cur_type_q;
      mux_data_d = tx_tdata;
    end else if (mux_wr_q && mux_wr_ready) begin
      mux_wr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_type_q <= T_NONE;
      words_q    <= 24'd0;
      ks_idx_q   <= 3'd0;
      to_cnt_q   <= 32'd0;
      abort_q    <= 1'b0;
      bad_cmd_q  <= 1'b0;
      mux_wr_q   <= 1'b0;
      mux_type_q <= T_NONE;
      mux_data_q <= 32'd0;
    end else begin
      cur_type_q <= cur_type_d;
      words_q    <= words_d;
      ks_idx_q   <= ks_idx_d;
      to_cnt_q   <= to_cnt_d;
      abort_q    <= abort_d;
      bad_cmd_q  <= bad_cmd_d;
      mux_wr_q   <= mux_wr_d;
      mux_type_q <= mux_type_d;
      mux_data_q <= mux_data_d;
    end
  end

  assign mux_wr         = mux_wr_q;
  assign mux_trans_type = mux_type_q;
  assign mux_wr_data    = mux_data_q;
  assign ks_idx         = ks_idx_q;
  assign cur_type       = cur_type_q;
  assign words_remain   = words_q;
  assign abort          = abort_q;
  assign bad_cmd        = bad_cmd_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_trans_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_trans_sched
// Brief    : Directed self-checking bench for usb_trans_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_trans_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl_tdata;
  logic        ctrl_tvalid;
  logic        ctrl_tready;
  logic [31:0] tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready;
  logic        mux_wr;
  logic        mux_wr_ready;
  logic [2:0]  mux_trans_type;
  logic [31:0] mux_wr_data;
  logic [31:0] rx_tdata;
  logic        rx_tvalid;
  logic        rx_tlast;
  logic        rx_tready;
  logic [2:0]  ks_idx;
  logic [31:0] ks_data;
  logic        busy;
  logic [2:0]  cur_type;
  logic [23:0] words_remain;
  logic        abort;
  logic        bad_cmd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb ks_data = 32'h5A00_0000 | {29'd0, ks_idx};

  usb_trans_sched #(
    .TIMEOUT_CYC (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ctrl_tdata     (ctrl_tdata),
    .ctrl_tvalid    (ctrl_tvalid),
    .ctrl_tready    (ctrl_tready),
    .tx_tdata       (tx_tdata),
    .tx_tvalid      (tx_tvalid),
    .tx_tready      (tx_tready),
    .mux_wr         (mux_wr),
    .mux_wr_ready   (mux_wr_ready),
    .mux_trans_type (mux_trans_type),
    .mux_wr_data    (mux_wr_data),
    .rx_tdata       (rx_tdata),
    .rx_tvalid      (rx_tvalid),
    .rx_tlast       (rx_tlast),
    .rx_tready      (rx_tready),
    .ks_idx         (ks_idx),
    .ks_data        (ks_data),
    .busy           (busy),
    .cur_type       (cur_type),
    .words_remain   (words_remain),
    .abort          (abort),
    .bad_cmd        (bad_cmd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_abort;
    int   b;

    rst = 1'b0; ctrl_tdata = '0; ctrl_tvalid = 1'b0; tx_tdata = '0; tx_tvalid = 1'b0;
    mux_wr_ready = 1'b1; rx_tready = 1'b0;
    repeat (3) step();
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_mux_wr", mux_wr, 0);
    chk("rst_words", words_remain, 0);
    chk("rst_type", cur_type, 0);
    chk("rst_rx_tvalid", rx_tvalid, 0);
    chk("rst_abort", abort, 0);
    chk("rst_bad", bad_cmd, 0);
    chk("rst_mux_data", mux_wr_data, 0);

    // Sound-left command, five words offered, four expected.
    rst = 1'b1; ctrl_tdata = 32'h6; ctrl_tvalid = 1'b1;
    settle();
    chk("sl_ctrl_rdy", ctrl_tready, 1);
    step();
    ctrl_tvalid = 1'b0;
    settle();
    chk("sl_busy", busy, 1);
    chk("sl_type", cur_type, 6);
    chk("sl_words", words_remain, 4);
    chk("sl_ctrl_rdy_busy", ctrl_tready, 0);
    for (int i = 0; i < 4; i++) begin
      tx_tdata = 32'hA000_0000 + 32'(i); tx_tvalid = 1'b1;
      settle();
      chk("sl_tx_rdy", tx_tready, 1);
      step();
      settle();
      chk("sl_mux_wr", mux_wr, 1);
      chk("sl_mux_data", mux_wr_data, 32'hA000_0000 + 32'(i));
      chk("sl_mux_type", mux_trans_type, 6);
      chk("sl_words_dec", words_remain, 32'(3 - i));
    end
    chk("sl_done_busy", busy, 0);
    chk("sl_done_ctrl_rdy", ctrl_tready, 1);
    tx_tdata = 32'hA000_0004;
    settle();
    chk("sl_5th_tx_rdy", tx_tready, 0);
    step();
    settle();
    chk("sl_drained", mux_wr, 0);
    chk("sl_last_data", mux_wr_data, 32'hA000_0003);

    // Video buffer with mux backpressure.
    tx_tvalid = 1'b0; ctrl_tdata = 32'h2; ctrl_tvalid = 1'b1;
    step();
    ctrl_tvalid = 1'b0;
    settle();
    chk("vb_words", words_remain, 32'h8000);
    tx_tdata = 32'h11; tx_tvalid = 1'b1;
    step();
    settle();
    chk("vb_data0", mux_wr_data, 32'h11);
    chk("vb_words0", words_remain, 32'h7FFF);
    mux_wr_ready = 1'b0; tx_tdata = 32'h22;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("vb_bp_tx_rdy", tx_tready, 0);
      step();
      settle();
      chk("vb_bp_data", mux_wr_data, 32'h11);
      chk("vb_bp_words", words_remain, 32'h7FFF);
      chk("vb_bp_abort", abort, 0);
    end
    mux_wr_ready = 1'b1;
    settle();
    chk("vb_rel_tx_rdy", tx_tready, 1);
    step();
    settle();
    chk("vb_data1", mux_wr_data, 32'h22);
    chk("vb_words1", words_remain, 32'h7FFE);
    mux_wr_ready = 1'b0; tx_tvalid = 1'b0;
    saw_abort = 1'b0;
    repeat (20) begin
      step();
      if (abort) saw_abort = 1'b1;
    end
    chk("vb_long_bp_no_abort", saw_abort, 0);
    chk("vb_long_bp_busy", busy, 1);
    mux_wr_ready = 1'b1; rst = 1'b0;
    step();
    rst = 1'b1;

    // Timeout with no tx data at all.
    ctrl_tdata = 32'h2; ctrl_tvalid = 1'b1;
    step();
    ctrl_tvalid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      settle();
      chk("to_early_abort", abort, 0);
    end
    chk("to_busy_before", busy, 1);
    step();
    settle();
    chk("to_abort", abort, 1);
    chk("to_busy_at", busy, 0);
    chk("to_words", words_remain, 0);
    step();
    settle();
    chk("to_abort_once", abort, 0);
    chk("to_busy_after", busy, 0);

    // Key/status read with alternating rx_tready.
    ctrl_tdata = 32'h3; ctrl_tvalid = 1'b1;
    step();
    ctrl_tvalid = 1'b0;
    settle();
    chk("ks_words", words_remain, 8);
    chk("ks_idx0", ks_idx, 0);
    chk("ks_type", cur_type, 3);
    chk("ks_valid", rx_tvalid, 1);
    b = 0;
    for (int c = 0; c < 16; c++) begin
      rx_tready = (c % 2 == 0);
      settle();
      if (rx_tready) begin
        chk("ks_idx", ks_idx, 32'(b));
        chk("ks_data", rx_tdata, 32'h5A00_0000 | 32'(b));
        chk("ks_last", rx_tlast, (b == 7) ? 32'd1 : 32'd0);
      end
      step();
      if (rx_tready) b++;
    end
    rx_tready = 1'b0;
    settle();
    chk("ks_done_busy", busy, 0);
    chk("ks_done_valid", rx_tvalid, 0);
    chk("ks_done_idx", ks_idx, 0);
    chk("ks_done_words", words_remain, 0);

    // Invalid and NONE commands.
    ctrl_tdata = 32'h4; ctrl_tvalid = 1'b1;
    step();
    ctrl_tvalid = 1'b0;
    settle();
    chk("bad4_pulse", bad_cmd, 1);
    chk("bad4_busy", busy, 0);
    step();
    settle();
    chk("bad4_once", bad_cmd, 0);
    ctrl_tdata = 32'hFFFF_FFF8; ctrl_tvalid = 1'b1;
    step();
    ctrl_tvalid = 1'b0;
    settle();
    chk("none_bad", bad_cmd, 0);
    chk("none_busy", busy, 0);
    ctrl_tdata = 32'hFFFF_FFF7; ctrl_tvalid = 1'b1;
    step();
    ctrl_tvalid = 1'b0;
    settle();
    chk("bad7_pulse", bad_cmd, 1);

    // Reset in the middle of a code transfer, then a normal sound transfer.
    ctrl_tdata = 32'h1; ctrl_tvalid = 1'b1;
    step();
    ctrl_tvalid = 1'b0;
    settle();
    chk("code_words", words_remain, 32'h40_0000);
    tx_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_tdata = 32'hB0 + 32'(i);
      step();
    end
    settle();
    chk("code_words_mid", words_remain, 32'h3F_FFF0);
    chk("code_mux_wr", mux_wr, 1);
    rst = 1'b0;
    step();
    settle();
    chk("mrst_busy", busy, 0);
    chk("mrst_mux_wr", mux_wr, 0);
    chk("mrst_words", words_remain, 0);
    chk("mrst_type", cur_type, 0);
    chk("mrst_data", mux_wr_data, 0);
    rst = 1'b1; tx_tvalid = 1'b0; ctrl_tdata = 32'h6; ctrl_tvalid = 1'b1;
    settle();
    chk("post_ctrl_rdy", ctrl_tready, 1);
    step();
    ctrl_tvalid = 1'b0;
    tx_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_tdata = 32'hD0 + 32'(i);
      step();
    end
    tx_tvalid = 1'b0;
    settle();
    chk("post_busy", busy, 0);
    chk("post_type", mux_trans_type, 6);
    chk("post_data", mux_wr_data, 32'hD3);
    chk("post_words", words_remain, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
